pixel_class_counter: RTL and testbench
======================================

# pixel_class_counter

- Parametrised successor to the fixed three-channel image counter.
- Each accepted pixel is classified by its dominant channel, and each channel keeps a per-image count and sum.
- At end of image the block reports tag, dominant type, dominant count and dominant sum.
- Adds a result register with full valid/ready backpressure, so the next image is accepted while the previous result waits.
- Sits between the pixel source and the image classifier/statistics stage.

## Interface
Parameters:
- N_CH, 3: channels per pixel (2..8)
- PIX_BIT, 8: bits per channel sample
- TAG_BIT, 8: image tag width
- IMG_SIZE, 1024: pixels per image (≥2)
- TYPE_BIT, $clog2(N_CH): derived, channel index width
- CNT_BIT, $clog2(IMG_SIZE+1): derived, count width
- SUM_BIT, PIX_BIT+CNT_BIT: derived, sum width (cannot overflow)

Ports:
- clk  in  1  clock; one clock domain, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- pixel_valid  in  1  pixel offered.
- pixel_ready  out  1  block accepts pixel; a transfer occurs on a clock edge with valid&&ready.
- pixel_data  in  [PIX_BIT-1:0] x N_CH  unpacked array, index 0 = channel 0.
- pixel_tag  in  TAG_BIT  tag; sampled on the first pixel of each image only.
- img_valid  out  1  result available.
- img_ready  in  1  downstream accepts result.
- img_tag  out  TAG_BIT  tag of the image.
- img_type  out  TYPE_BIT  dominant channel of the image.
- img_num  out  CNT_BIT  pixel count of the dominant channel.
- img_sum  out  SUM_BIT  sum of dominant-channel samples over those pixels.

## Operation
- Pixel class: the index of the maximum pixel_data[c]; ties go to the lowest index.
- On each accepted pixel of class c:
  - cnt[c] += 1
  - sum[c] += pixel_data[c]
  - pixel index += 1
- When the pixel index is 0, pixel_tag is latched as the image tag.
- FSM states:
  - ACC:
    - pixel_ready=1.
    - On acceptance of pixel number IMG_SIZE-1 (zero-based), go to RESOLVE.
  - RESOLVE:
    - pixel_ready=0.
    - type = argmax over cnt[]; ties go to the lowest index.
    - If the result register is empty, or is being drained this cycle (img_valid&&img_ready), load {tag, type, cnt[type], sum[type]}, set img_valid, clear cnt/sum/index, and go to ACC.
    - Otherwise stay in RESOLVE, accumulators held.
- Result register: img_valid clears on img_valid&&img_ready unless it is reloaded in the same cycle. Outputs are stable while img_valid=1 and img_ready=0.
- pixel_data is ignored when pixel_valid=0 or pixel_ready=0; the pixel index does not advance on idle cycles.
- Reset values:
  - FSM=ACC, pixel_ready=1.
  - img_valid=0, img_tag=0, img_type=0, img_num=0, img_sum=0.
  - All accumulators and the pixel index are 0.
- Reset mid-image or mid-RESOLVE discards the partial image and any unconsumed result.

## Timing
- Latency: last pixel accepted at edge k, img_valid=1 after edge k+1 when the result register is free.
- Throughput: one image per IMG_SIZE+1 cycles under continuous valid/ready (one RESOLVE bubble).
- pixel_ready is a registered FSM decode with no combinational path from img_ready. img_ready affects only the next-edge state.
- A result is held indefinitely under img_ready=0. The following image fully accumulates, then stalls in RESOLVE with pixel_ready=0.

## Configuration
- PIXEL_LAST_EN defined:
  - Adds input pixel_last (1 bit).
  - An image ends on acceptance of a pixel with pixel_last=1, or at IMG_SIZE pixels, whichever comes first.
  - A pixel_last=1 on pixel 0 yields a one-pixel image.
- PIXEL_LAST_EN undefined:
  - The port is absent.
  - Images are exactly IMG_SIZE pixels.

## Test plan
Bench uses N_CH=3, PIX_BIT=8, IMG_SIZE=4.
- Basic: pixels (10,5,5),(3,9,1),(7,7,2),(0,0,0), tag 0x2A on the first pixel, img_ready=1 -> img_valid one cycle after the 4th pixel; tag=0x2A, type=0, num=3, sum=17.
- Count tie: (9,0,0),(8,0,0),(0,9,0),(0,7,0) -> type=0, num=2, sum=17. Then (0,9,0),(0,8,0),(0,0,9),(0,0,5) -> type=1, num=2, sum=17.
- Backpressure: hold img_ready=0 for 20 cycles over two back-to-back images -> the first result stays stable, and pixel_ready=0 in RESOLVE after the second image's 4th pixel. On img_ready=1 the second result loads in the same cycle the first drains, then pixel_ready=1 on the next cycle.
- Bubbles: pixel_valid toggling 1,0,0,1,... with the basic pixels -> same result as the basic case; tag is taken from the first accepted pixel only.
- Reset: assert rst for 1 cycle after 2 pixels, then send the basic image -> only the basic result appears (tag=0x2A, type=0, num=3, sum=17).
- PIXEL_LAST_EN: (1,2,3),(4,2,1) with pixel_last on the 2nd pixel -> type=0, num=1, sum=4. (Both channels have count 1; the tie goes to channel 0.)

Source files
------------

// File: rtl/pixel_class_counter.sv
// Purpose : classifies each pixel by its dominant channel, keeps per-image
//           per-channel count and sum, and reports the dominant channel of
//           the image (tag, type, count, sum) through a result register.
// Latency : last pixel accepted at edge k -> img_valid=1 after edge k+1
//           when the result register is free (one RESOLVE cycle per image).
// Backpressure: the result is held under img_ready=0. The next image
//           accumulates fully, then waits in RESOLVE with pixel_ready=0.
//           pixel_ready is a registered state decode with no combinational
//           path from img_ready.
// Ports   : clk/rst (sync, active-high); pixel_valid/pixel_ready/pixel_data
//           [N_CH]/pixel_tag in; img_valid/img_ready/img_tag/img_type/
//           img_num/img_sum out.
// Option  : `define PIXEL_LAST_EN adds input pixel_last, which ends an image
//           early on an accepted pixel with pixel_last=1.
module pixel_class_counter #(
   parameter int N_CH     = 3,
   parameter int PIX_BIT  = 8,
   parameter int TAG_BIT  = 8,
   parameter int IMG_SIZE = 1024,
   parameter int TYPE_BIT = $clog2(N_CH),
   parameter int CNT_BIT  = $clog2(IMG_SIZE + 1),
   parameter int SUM_BIT  = PIX_BIT + CNT_BIT
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                pixel_valid,
   output logic                pixel_ready,
   input  logic [PIX_BIT-1:0]  pixel_data [N_CH],
   input  logic [TAG_BIT-1:0]  pixel_tag,
`ifdef PIXEL_LAST_EN
   input  logic                pixel_last,
`endif
   output logic                img_valid,
   input  logic                img_ready,
   output logic [TAG_BIT-1:0]  img_tag,
   output logic [TYPE_BIT-1:0] img_type,
   output logic [CNT_BIT-1:0]  img_num,
   output logic [SUM_BIT-1:0]  img_sum
);

   typedef enum logic {
      ST_ACC     = 1'b0,
      ST_RESOLVE = 1'b1
   } state_t;

   localparam logic [CNT_BIT-1:0] C_LAST_IDX = CNT_BIT'(IMG_SIZE - 1);

   state_t              r_state;
   logic                r_pixel_ready;
   logic [CNT_BIT-1:0]  r_idx;
   logic [TAG_BIT-1:0]  r_tag;
   logic [CNT_BIT-1:0]  r_cnt [N_CH];
   logic [SUM_BIT-1:0]  r_sum [N_CH];

   logic                r_img_valid;
   logic [TAG_BIT-1:0]  r_img_tag;
   logic [TYPE_BIT-1:0] r_img_type;
   logic [CNT_BIT-1:0]  r_img_num;
   logic [SUM_BIT-1:0]  r_img_sum;

   logic [TYPE_BIT-1:0] w_cls;
   logic [PIX_BIT-1:0]  w_max;
   logic [TYPE_BIT-1:0] w_type;
   logic [CNT_BIT-1:0]  w_best_cnt;
   logic                w_accept;
   logic                w_last;
   logic                w_res_free;

   // Pixel class: strict '>' keeps the lowest index on ties.
   always_comb begin
      w_cls = '0;
      w_max = pixel_data[0];
      for (int c = 1; c < N_CH; c++) begin
         if (pixel_data[c] > w_max) begin
            w_max = pixel_data[c];
            w_cls = TYPE_BIT'(c);
         end
      end
   end

   // Dominant type of the image: argmax over counts, lowest index on ties.
   always_comb begin
      w_type     = '0;
      w_best_cnt = r_cnt[0];
      for (int c = 1; c < N_CH; c++) begin
         if (r_cnt[c] > w_best_cnt) begin
            w_best_cnt = r_cnt[c];
            w_type     = TYPE_BIT'(c);
         end
      end
   end

   assign w_accept = pixel_valid && r_pixel_ready;

`ifdef PIXEL_LAST_EN
   assign w_last = (r_idx == C_LAST_IDX) || pixel_last;
`else
   assign w_last = (r_idx == C_LAST_IDX);
`endif

   // Result register can take a new value if empty or draining this cycle.
   assign w_res_free = !r_img_valid || img_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state       <= ST_ACC;
         r_pixel_ready <= 1'b1;
         r_idx         <= '0;
         r_tag         <= '0;
         for (int c = 0; c < N_CH; c++) begin
            r_cnt[c] <= '0;
            r_sum[c] <= '0;
         end
         r_img_valid   <= 1'b0;
         r_img_tag     <= '0;
         r_img_type    <= '0;
         r_img_num     <= '0;
         r_img_sum     <= '0;
      end else begin
         // Drain first; a reload below in the same cycle overrides this.
         if (r_img_valid && img_ready) begin
            r_img_valid <= 1'b0;
         end

         case (r_state)
            ST_ACC: begin
               if (w_accept) begin
                  r_cnt[w_cls] <= r_cnt[w_cls] + CNT_BIT'(1);
                  r_sum[w_cls] <= r_sum[w_cls] + SUM_BIT'(w_max);
                  r_idx        <= r_idx + CNT_BIT'(1);
                  if (r_idx == '0) begin
                     r_tag <= pixel_tag;
                  end
                  if (w_last) begin
                     r_state       <= ST_RESOLVE;
                     r_pixel_ready <= 1'b0;
                  end
               end
            end

            ST_RESOLVE: begin
               if (w_res_free) begin
                  r_img_valid <= 1'b1;
                  r_img_tag   <= r_tag;
                  r_img_type  <= w_type;
                  r_img_num   <= w_best_cnt;
                  r_img_sum   <= r_sum[w_type];
                  r_idx       <= '0;
                  for (int c = 0; c < N_CH; c++) begin
                     r_cnt[c] <= '0;
                     r_sum[c] <= '0;
                  end
                  r_state       <= ST_ACC;
                  r_pixel_ready <= 1'b1;
               end
            end

            default: begin
               r_state       <= ST_ACC;
               r_pixel_ready <= 1'b1;
            end
         endcase
      end
   end

   assign pixel_ready = r_pixel_ready;
   assign img_valid   = r_img_valid;
   assign img_tag     = r_img_tag;
   assign img_type    = r_img_type;
   assign img_num     = r_img_num;
   assign img_sum     = r_img_sum;

endmodule

// File: tb/tb_pixel_class_counter.sv
// Directed bench for pixel_class_counter (N_CH=3, PIX_BIT=8, IMG_SIZE=4).
// Inputs are driven and outputs sampled on the falling clock edge.
// Expected values are hand-computed from the pixel vectors below.
module tb_pixel_class_counter;

   localparam int N_CH     = 3;
   localparam int PIX_BIT  = 8;
   localparam int TAG_BIT  = 8;
   localparam int IMG_SIZE = 4;
   localparam int TYPE_BIT = $clog2(N_CH);
   localparam int CNT_BIT  = $clog2(IMG_SIZE + 1);
   localparam int SUM_BIT  = PIX_BIT + CNT_BIT;

   logic                clk = 1'b0;
   logic                rst;
   logic                pixel_valid;
   logic                pixel_ready;
   logic [PIX_BIT-1:0]  pix [N_CH];
   logic [TAG_BIT-1:0]  pixel_tag;
`ifdef PIXEL_LAST_EN
   logic                pixel_last;
`endif
   logic                img_valid;
   logic                img_ready;
   logic [TAG_BIT-1:0]  img_tag;
   logic [TYPE_BIT-1:0] img_type;
   logic [CNT_BIT-1:0]  img_num;
   logic [SUM_BIT-1:0]  img_sum;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   pixel_class_counter #(
      .N_CH(N_CH), .PIX_BIT(PIX_BIT), .TAG_BIT(TAG_BIT), .IMG_SIZE(IMG_SIZE)
   ) dut (
      .clk(clk),
      .rst(rst),
      .pixel_valid(pixel_valid),
      .pixel_ready(pixel_ready),
      .pixel_data(pix),
      .pixel_tag(pixel_tag),
`ifdef PIXEL_LAST_EN
      .pixel_last(pixel_last),
`endif
      .img_valid(img_valid),
      .img_ready(img_ready),
      .img_tag(img_tag),
      .img_type(img_type),
      .img_num(img_num),
      .img_sum(img_sum)
   );

   task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
      end
   endtask

   // Offer one pixel (at a falling edge) and return at the falling edge
   // after the rising edge that accepted it.
   task automatic push(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                       input logic [7:0] tag, input logic lst);
      int n = 0;
      pixel_valid = 1'b1;
      pix[0] = a; pix[1] = b; pix[2] = c;
      pixel_tag = tag;
`ifdef PIXEL_LAST_EN
      pixel_last = lst;
`else
      if (lst) n = 0;
`endif
      while (!pixel_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (n >= 50) check("push_timeout", 32'(n), 32'(0));
      @(negedge clk);
      pixel_valid = 1'b0;
`ifdef PIXEL_LAST_EN
      pixel_last = 1'b0;
`endif
   endtask

   // Wait (bounded) for a result, compare it, then let it drain.
   task automatic expect_result(input string name, input logic [7:0] tag,
                                input int typ, input int num, input int sum);
      int n = 0;
      while (!img_valid && n < 20) begin
         @(negedge clk);
         n++;
      end
      check({name, "_valid"}, 32'(img_valid), 32'(1));
      check({name, "_tag"},   32'(img_tag),   32'(tag));
      check({name, "_type"},  32'(img_type),  32'(typ));
      check({name, "_num"},   32'(img_num),   32'(num));
      check({name, "_sum"},   32'(img_sum),   32'(sum));
      @(negedge clk);
      check({name, "_drained"}, 32'(img_valid), 32'(0));
   endtask

   task automatic push_basic(input logic [7:0] tag0, input logic [7:0] tagn);
      push(8'd10, 8'd5, 8'd5, tag0, 1'b0);
      push(8'd3,  8'd9, 8'd1, tagn, 1'b0);
      push(8'd7,  8'd7, 8'd2, tagn, 1'b0);
      push(8'd0,  8'd0, 8'd0, tagn, 1'b0);
   endtask

   initial begin
      logic stable;
      rst = 1'b1;
      pixel_valid = 1'b0;
      pix[0] = '0; pix[1] = '0; pix[2] = '0;
      pixel_tag = '0;
      img_ready = 1'b1;
`ifdef PIXEL_LAST_EN
      pixel_last = 1'b0;
`endif
      repeat (2) @(negedge clk);
      // Reset state
      check("rst_pixel_ready", 32'(pixel_ready), 32'(1));
      check("rst_img_valid",   32'(img_valid),   32'(0));
      check("rst_img_tag",     32'(img_tag),     32'(0));
      check("rst_img_type",    32'(img_type),    32'(0));
      check("rst_img_num",     32'(img_num),     32'(0));
      check("rst_img_sum",     32'(img_sum),     32'(0));
      rst = 1'b0;
      @(negedge clk);

      // Basic: result one cycle after the 4th pixel
      push_basic(8'h2A, 8'h2A);
      check("basic_resolve_ready", 32'(pixel_ready), 32'(0));
      check("basic_resolve_valid", 32'(img_valid),   32'(0));
      @(negedge clk);
      check("basic_latency_valid", 32'(img_valid),   32'(1));
      check("basic_ready_back",    32'(pixel_ready), 32'(1));
      expect_result("basic", 8'h2A, 0, 3, 17);

      // Count tie -> lowest channel
      push(8'd9, 8'd0, 8'd0, 8'h11, 1'b0);
      push(8'd8, 8'd0, 8'd0, 8'h11, 1'b0);
      push(8'd0, 8'd9, 8'd0, 8'h11, 1'b0);
      push(8'd0, 8'd7, 8'd0, 8'h11, 1'b0);
      expect_result("tie1", 8'h11, 0, 2, 17);
      push(8'd0, 8'd9, 8'd0, 8'h22, 1'b0);
      push(8'd0, 8'd8, 8'd0, 8'h22, 1'b0);
      push(8'd0, 8'd0, 8'd9, 8'h22, 1'b0);
      push(8'd0, 8'd0, 8'd5, 8'h22, 1'b0);
      expect_result("tie2", 8'h22, 1, 2, 17);

      // Backpressure over two back-to-back images
      img_ready = 1'b0;
      push_basic(8'h2A, 8'h2A);
      push(8'd0, 8'd9, 8'd0, 8'h22, 1'b0);
      push(8'd0, 8'd8, 8'd0, 8'h22, 1'b0);
      push(8'd0, 8'd0, 8'd9, 8'h22, 1'b0);
      push(8'd0, 8'd0, 8'd5, 8'h22, 1'b0);
      check("bp_stall_ready", 32'(pixel_ready), 32'(0));
      check("bp_hold_valid",  32'(img_valid),   32'(1));
      check("bp_hold_tag",    32'(img_tag),     32'(8'h2A));
      // A pixel offered during the stall must be ignored
      pixel_valid = 1'b1;
      pix[0] = 8'd200; pix[1] = 8'd0; pix[2] = 8'd0;
      pixel_tag = 8'hEE;
      stable = 1'b1;
      for (int i = 0; i < 18; i++) begin
         @(negedge clk);
         if (!img_valid || img_tag !== 8'h2A || img_type !== 2'd0 ||
             img_num !== 3'd3 || img_sum !== 11'd17 || pixel_ready !== 1'b0)
            stable = 1'b0;
      end
      check("bp_held_stable", 32'(stable), 32'(1));
      img_ready = 1'b1;
      pixel_valid = 1'b0;
      @(negedge clk);
      check("bp_reload_ready", 32'(pixel_ready), 32'(1));
      expect_result("bp_second", 8'h22, 1, 2, 17);

      // Bubbles: valid 1,0,0,1,... ; tag only from the first accepted pixel
      push(8'd10, 8'd5, 8'd5, 8'h2A, 1'b0);
      pix[0] = 8'd99; pix[1] = 8'd99; pix[2] = 8'd99; pixel_tag = 8'h55;
      repeat (2) @(negedge clk);
      push(8'd3, 8'd9, 8'd1, 8'h55, 1'b0);
      pix[0] = 8'd99; pix[1] = 8'd99; pix[2] = 8'd99;
      repeat (2) @(negedge clk);
      push(8'd7, 8'd7, 8'd2, 8'h56, 1'b0);
      pix[0] = 8'd99; pix[1] = 8'd99; pix[2] = 8'd99;
      repeat (2) @(negedge clk);
      check("bubble_no_early", 32'(img_valid), 32'(0));
      push(8'd0, 8'd0, 8'd0, 8'h57, 1'b0);
      expect_result("bubble", 8'h2A, 0, 3, 17);

      // Reset mid-image discards the partial image
      push(8'd50, 8'd0, 8'd0, 8'h77, 1'b0);
      push(8'd50, 8'd0, 8'd0, 8'h77, 1'b0);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("midrst_ready", 32'(pixel_ready), 32'(1));
      check("midrst_valid", 32'(img_valid),   32'(0));
      push_basic(8'h2A, 8'h2A);
      expect_result("after_rst", 8'h2A, 0, 3, 17);

`ifdef PIXEL_LAST_EN
      // Early end of image via pixel_last
      push(8'd1, 8'd2, 8'd3, 8'h33, 1'b0);
      push(8'd4, 8'd2, 8'd1, 8'h33, 1'b1);
      check("last_resolve_ready", 32'(pixel_ready), 32'(0));
      expect_result("last", 8'h33, 0, 1, 4);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

endmodule
